// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, pointer type and Gray encoding helper.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_SIZE = 6;

  typedef logic [FIFO_ADDR_SIZE:0] ptr_t;

  // Operates on a wide vector so any pointer width can use it through a size cast.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down); shared by both pointer domains.
module gray2bin #(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer / FULL / ALMOST_FULL / fill-level controller for the async FIFO.
// Optional sticky overflow output W_OVF when WPTR_OVERFLOW_FLAG_EN is defined.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE    = FIFO_ADDR_SIZE,
  parameter int unsigned AFULL_THRESH = 56
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 W_INC,
  input  logic [ADDR_SIZE:0]   R_Ptr_Sync,
  output logic                 W_EN,
  output logic [ADDR_SIZE-1:0] W_Address,
  output logic [ADDR_SIZE:0]   W_Ptr_Gray,
  output logic                 FULL,
  output logic                 ALMOST_FULL,
`ifdef WPTR_OVERFLOW_FLAG_EN
  output logic                 W_OVF,
`endif
  output logic [ADDR_SIZE:0]   W_Level
);

  localparam int unsigned PTR_W = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  logic [ADDR_SIZE:0] wbin_q, wbin_d;
  logic [ADDR_SIZE:0] wgray_q, wgray_d;
  logic [ADDR_SIZE:0] level_q, level_d;
  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] full_cmp;
  logic               full_q, full_d;
  logic               afull_q, afull_d;
  logic               w_en;

  gray2bin #(.WIDTH(PTR_W)) u_rptr_g2b (
    .gray_i (R_Ptr_Sync),
    .bin_o  (rbin)
  );

  // Full when the next write pointer has lapped the read pointer: top two Gray bits inverted.
  always_comb begin
    w_en     = W_INC & ~full_q;
    wbin_d   = wbin_q + PTR_W'(w_en);
    wgray_d  = PTR_W'(bin2gray(32'(wbin_d)));
    full_cmp = {~R_Ptr_Sync[ADDR_SIZE:ADDR_SIZE-1], R_Ptr_Sync[ADDR_SIZE-2:0]};
    full_d   = (wgray_d == full_cmp);
    level_d  = wbin_d - rbin;
    afull_d  = (level_d >= AFULL_LVL);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
    end
  end

`ifdef WPTR_OVERFLOW_FLAG_EN
  logic ovf_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (W_INC & full_q);
    end
  end

  assign W_OVF = ovf_q;
`endif

  assign W_EN        = w_en;
  assign W_Address   = wbin_q[ADDR_SIZE-1:0];
  assign W_Ptr_Gray  = wgray_q;
  assign FULL        = full_q;
  assign ALMOST_FULL = afull_q;
  assign W_Level     = level_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl: reference model counts writes/reads as plain integers.
module tb_wptr_full_ctrl;

  localparam int AS    = 6;
  localparam int DEPTH = 64;
  localparam int THR   = 56;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_inc = 1'b0;
  logic [6:0] r_ptr = '0;
  logic       w_en;
  logic [5:0] w_addr;
  logic [6:0] w_gray;
  logic       full;
  logic       afull;
  logic [6:0] w_level;
`ifdef WPTR_OVERFLOW_FLAG_EN
  logic       w_ovf;
`endif

  wptr_full_ctrl #(.ADDR_SIZE(AS), .AFULL_THRESH(THR)) dut (
`ifdef WPTR_OVERFLOW_FLAG_EN
    .W_OVF       (w_ovf),
`endif
    .CLK         (clk),
    .RST_n       (rst_n),
    .W_INC       (w_inc),
    .R_Ptr_Sync  (r_ptr),
    .W_EN        (w_en),
    .W_Address   (w_addr),
    .W_Ptr_Gray  (w_gray),
    .FULL        (full),
    .ALMOST_FULL (afull),
    .W_Level     (w_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w_en;
    int addr;
    int gray;
    int full;
    int af;
    int level;
    int ovf;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: total accepted writes and read count as unbounded integers.
  int   wcnt, rcnt, m_lvl;
  bit   m_full, m_af, m_ovf;

  function automatic logic [6:0] gray_of(input int v);
    logic [6:0] b;
    b = v[6:0];
    return b ^ (b >> 1);
  endfunction

  function automatic void check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    wcnt = 0; rcnt = 0; m_lvl = 0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
  endfunction

  // Called at posedge+1: drive one cycle, queue what the DUT must show, advance the model.
  task automatic step(input bit inc, input int rnew);
    exp_t e;
    bit   acc;
    w_inc = inc;
    rcnt  = rnew;
    r_ptr = gray_of(rnew);
    acc   = inc && !m_full;
    e.w_en  = int'(acc);
    e.addr  = wcnt % DEPTH;
    e.gray  = int'(gray_of(wcnt));
    e.full  = int'(m_full);
    e.af    = int'(m_af);
    e.level = m_lvl;
    e.ovf   = int'(m_ovf);
    sbq.push_back(e);
    m_ovf  = m_ovf | (inc && m_full);
    wcnt   = wcnt + int'(acc);
    m_lvl  = wcnt - rcnt;
    m_full = (m_lvl == DEPTH);
    m_af   = (m_lvl >= THR);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    w_inc = 1'b1;
    #1;
    check("rst_addr",  int'(w_addr),  0);
    check("rst_gray",  int'(w_gray),  0);
    check("rst_full",  int'(full),    0);
    check("rst_afull", int'(afull),   0);
    check("rst_level", int'(w_level), 0);
    check("rst_w_en",  int'(w_en),    1);
`ifdef WPTR_OVERFLOW_FLAG_EN
    check("rst_ovf",   int'(w_ovf),   0);
`endif
    w_inc = 1'b0;
    r_ptr = '0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("w_en",  int'(w_en),    e.w_en);
        check("addr",  int'(w_addr),  e.addr);
        check("gray",  int'(w_gray),  e.gray);
        check("full",  int'(full),    e.full);
        check("afull", int'(afull),   e.af);
        check("level", int'(w_level), e.level);
`ifdef WPTR_OVERFLOW_FLAG_EN
        check("ovf",   int'(w_ovf),   e.ovf);
`endif
      end
    end
  end

  initial begin
    int hist[$];
    int rnew;
    bit inc;
    int guard;

    model_reset();
    do_reset();

    for (int i = 0; i < 30; i++) step(1'b1, 0);
    do_reset();

    for (int i = 0; i < 64; i++) begin
      step(1'b1, 0);
      if (i == 55) check("afull_at_56", int'(afull), 1);
      if (i == 54) check("afull_at_55", int'(afull), 0);
    end
    check("fill_full",  int'(full),    1);
    check("fill_gray",  int'(w_gray),  96);
    check("fill_level", int'(w_level), 64);
    check("fill_addr",  int'(w_addr),  0);

    step(1'b1, 0);
    check("wfull_level", int'(w_level), 64);
    check("wfull_gray",  int'(w_gray),  96);
`ifdef WPTR_OVERFLOW_FLAG_EN
    check("ovf_set", int'(w_ovf), 1);
`endif

    step(1'b0, 1);
    check("drain_full",  int'(full),    0);
    check("drain_level", int'(w_level), 63);
    check("drain_afull", int'(afull),   1);
    w_inc = 1'b1;
    #1;
    check("drain_w_en", int'(w_en),   1);
    check("drain_addr", int'(w_addr), 0);
    step(1'b1, 1);
    step(1'b0, 1);

    do_reset();
    hist.delete();
    for (int i = 0; i < 130; i++) begin
      rnew = (hist.size() >= 3) ? hist[hist.size()-3] : 0;
      step(1'b1, rnew);
      hist.push_back(wcnt);
      if (i == 127) check("wrap_gray0", int'(w_gray), 0);
    end

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      inc  = ($urandom_range(0, 99) < 75);
      rnew = rcnt;
      if ($urandom_range(0, 3) == 0) rnew = rcnt + int'($urandom_range(0, wcnt - rcnt));
      step(inc, rnew);
    end
    w_inc = 1'b0;

    guard = 0;
    while (sbq.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    check("sb_drain", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-domain pointer and full-flag controller for the asynchronous FIFO.
- Maintains the binary and Gray write pointers and drives the dual-port memory write address and write enable.
- Its Gray pointer feeds the read-domain synchronizer.
- Consumes the read pointer, already synchronized into the write clock, to generate FULL, ALMOST_FULL and a fill-level estimate.

Parameters:
- ADDR_SIZE, 6, memory address width; FIFO depth = 2^ADDR_SIZE; must be >= 2.
- AFULL_THRESH, 56, fill level (entries) at or above which ALMOST_FULL asserts; range 1..2^ADDR_SIZE.

Ports:
- CLK  input  1  write-domain clock.
- RST_n  input  1  asynchronous active-low reset.
- W_INC  input  1  write request from producer.
- R_Ptr_Sync  input  ADDR_SIZE+1  read pointer (Gray), already 2-flop synchronized into CLK.
- W_EN  output  1  memory write enable = W_INC & ~FULL (combinational).
- W_Address  output  ADDR_SIZE  memory write address = wbin[ADDR_SIZE-1:0].
- W_Ptr_Gray  output  ADDR_SIZE+1  registered Gray write pointer, to read-domain synchronizer.
- FULL  output  1  registered full flag.
- ALMOST_FULL  output  1  registered almost-full flag.
- W_Level  output  ADDR_SIZE+1  registered fill estimate, 0..2^ADDR_SIZE.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_n; all flops are cleared on RST_n falling, with no clock required.
- Reset values: wbin=0, W_Ptr_Gray=0, FULL=0, ALMOST_FULL=0, W_Level=0.
- Reset mid-operation: the same clear applies immediately. The write-side state does not depend on R_Ptr_Sync history.
- Pointer update:
  - wbin_next = wbin + (W_INC & ~FULL), modulo 2^(ADDR_SIZE+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - Both are registered every CLK edge.
- Memory write: the memory captures data at W_Address on the same edge where W_EN=1.
- Full detection:
  - full_next = (wgray_next == {~R_Ptr_Sync[ADDR_SIZE:ADDR_SIZE-1], R_Ptr_Sync[ADDR_SIZE-2:0]}).
  - FULL is registered, so it is high in the cycle immediately after the filling write.
- Write while FULL: ignored. W_EN=0, and wbin, W_Ptr_Gray and W_Level hold.
- FULL deassertion is pessimistic. It occurs one CLK edge after R_Ptr_Sync advances, which itself lags the actual read by the synchronizer latency. No entry is ever overwritten.
- Fill level:
  - rbin = gray2bin(R_Ptr_Sync).
  - W_Level <= wbin_next - rbin, modulo 2^(ADDR_SIZE+1).
  - The value never exceeds 2^ADDR_SIZE, and it is an over-estimate by design.
- Almost-full: ALMOST_FULL <= (level_next >= AFULL_THRESH), registered. ALMOST_FULL is always high when FULL is high.
- Wrap-around: wbin wraps from 2^(ADDR_SIZE+1)-1 to 0. The MSB toggle distinguishes full from empty. W_Address wraps from 2^ADDR_SIZE-1 to 0.
- Simultaneous write and read-pointer advance while FULL=1: the write is rejected, because FULL is the registered value. FULL drops on that edge only if full_next=0.
- The only state is the counter; there is no FSM.

Optional Feature:
- Macro: WPTR_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output W_OVF (1 bit, reset 0).
  - W_OVF is sticky and set on the edge after any cycle with W_INC=1 and FULL=1.
  - Only RST_n clears it.
- Undefined: the W_OVF port and its logic are absent. Rejected writes are silently dropped.

Decomposition:
- Package fifo_pkg:
  - default ADDR_SIZE constant;
  - bin2gray function;
  - ptr_t typedef (ADDR_SIZE+1 bits).
- Sub-module gray2bin, parameterized WIDTH, purely combinational XOR-prefix. It is reused by the read-side controller.

Test Plan:
- Reset: apply RST_n=0 mid-cycle after 30 writes -> all outputs read 0 before the next CLK edge. W_EN follows W_INC afterwards.
- Fill: R_Ptr_Sync=0, 64 consecutive writes -> FULL=1 after the 64th edge, W_Ptr_Gray=7'b1100000, W_Level=64, W_Address=0. ALMOST_FULL rose after the 56th write.
- Write while full: a 65th W_INC=1 -> W_EN=0, and pointers and W_Level are unchanged. With WPTR_OVERFLOW_FLAG_EN, W_OVF=1 on the next edge and stays 1.
- Drain release: from full, set R_Ptr_Sync=7'b0000001 -> FULL=0 after one edge, W_Level=63, ALMOST_FULL still 1. The next write is accepted at W_Address=0.
- Wrap: R_Ptr_Sync tracks wgray delayed 3 cycles, 130 writes -> W_Address sequence 63->0 with no gaps. W_Ptr_Gray returns to 0 after 128 writes. FULL never asserts.
- Random: random W_INC and monotone Gray R_Ptr_Sync advances -> scoreboard confirms FULL exactly when level_next = 64. No W_EN is issued while FULL=1.
